// File: rtl/rapid_pkg.sv
// Shared RAPID memory-stage types: access sizes, LSU fault codes, FSM states and defaults.
package rapid_pkg;

  typedef enum logic [1:0] {
    SizeByte  = 2'd0,
    SizeHalf  = 2'd1,
    SizeWord  = 2'd2,
    SizeDword = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    FaultNone     = 2'd0,
    FaultMisalign = 2'd1,
    FaultTimeout  = 2'd2
  } lsu_fault_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } lsu_state_e;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  // Bit mask covering the low 2^size bytes; callers truncate to their datapath width.
  function automatic logic [63:0] lsu_keep_mask(lsu_size_e size);
    case (size)
      SizeByte: lsu_keep_mask = 64'h0000_0000_0000_00FF;
      SizeHalf: lsu_keep_mask = 64'h0000_0000_0000_FFFF;
      SizeWord: lsu_keep_mask = 64'h0000_0000_FFFF_FFFF;
      default:  lsu_keep_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Execute/writeback/cache bundle of the RAPID load/store unit; master is the LSU side.
interface lsu_stage_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned NB = XLEN / 8;

  logic            i_valid;
  logic            i_load;
  logic            i_store;
  logic [1:0]      i_size;
  logic            i_unsigned;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_wdata;
  logic [4:0]      i_rd;
  logic            o_ready;
  logic            o_c_req;
  logic            o_c_we;
  logic [XLEN-1:0] o_c_addr;
  logic [XLEN-1:0] o_c_wdata;
  logic [NB-1:0]   o_c_be;
  logic            i_c_ack;
  logic [XLEN-1:0] i_c_rdata;
  logic            o_valid;
  logic [XLEN-1:0] o_rdata;
  logic [4:0]      o_rd;
  logic [1:0]      o_fault;

  modport master (
    input  i_valid, i_load, i_store, i_size, i_unsigned, i_addr, i_wdata, i_rd,
    input  i_c_ack, i_c_rdata,
    output o_ready, o_c_req, o_c_we, o_c_addr, o_c_wdata, o_c_be,
    output o_valid, o_rdata, o_rd, o_fault
  );

  modport slave (
    output i_valid, i_load, i_store, i_size, i_unsigned, i_addr, i_wdata, i_rd,
    output i_c_ack, i_c_rdata,
    input  o_ready, o_c_req, o_c_we, o_c_addr, o_c_wdata, o_c_be,
    input  o_valid, o_rdata, o_rd, o_fault
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store replication and load extension.
// Assumes a naturally aligned offset; shared with the future fetch aligner.
module lsu_align
  import rapid_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned NB   = XLEN / 8,
  localparam int unsigned OffW = $clog2(NB)
) (
  input  lsu_size_e       size_i,
  input  logic [OffW-1:0] off_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    keep    = XLEN'(lsu_keep_mask(size_i));
    be_o    = '0;
    wdata_o = wdata_i;
    sign    = 1'b0;
    unique case (size_i)
      SizeByte: begin
        be_o    = NB'(1) << off_i;
        wdata_o = {NB{wdata_i[7:0]}};
        sign    = shifted[7];
      end
      SizeHalf: begin
        be_o    = NB'(3) << off_i;
        wdata_o = {(NB/2){wdata_i[15:0]}};
        sign    = shifted[15];
      end
      SizeWord: begin
        be_o    = NB'(15) << off_i;
        wdata_o = {(NB/4){wdata_i[31:0]}};
        sign    = shifted[31];
      end
      default: begin
        be_o    = '1;
        wdata_o = wdata_i;
        sign    = shifted[XLEN-1];
      end
    endcase
    rdata_o = (shifted & keep) | ((sign && !unsigned_i) ? ~keep : '0);
  end

endmodule

// File: rtl/lsu_stage.sv
// RAPID memory-stage load/store unit: cache req/ack handshake, alignment, timeout.
// Build option RAPID_MISALIGN_TRAP_EN: fault misaligned accesses instead of force-aligning.
module lsu_stage
  import rapid_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
  input logic         i_clk,
  input logic         i_reset,
  lsu_stage_if.master lsu
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  lsu_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            ready_q, valid_q, c_req_q, c_we_q;
  logic [XLEN-1:0] c_addr_q, c_wdata_q, res_q, cdata_q;
  logic [NB-1:0]   c_be_q;
  logic [4:0]      rd_out_q, op_rd_q;
  lsu_fault_e      fault_out_q, op_fault_q;
  logic            op_store_q, op_uns_q;
  lsu_size_e       op_size_q;
  logic [OffW-1:0] op_off_q;

  lsu_size_e       size_req, size_eff, al_size;
  logic            dword_bad, timeout_hit;
  logic [OffW-1:0] off_raw, off_eff, size_mask, al_off;
  logic [NB-1:0]   al_be;
  logic [XLEN-1:0] al_wdata, al_rdata, c_addr_next;

  always_comb begin
    size_req  = lsu_size_e'(lsu.i_size);
    dword_bad = (XLEN == 32) && (size_req == SizeDword);
    size_eff  = dword_bad ? SizeWord : size_req;
    unique case (size_eff)
      SizeByte: size_mask = '0;
      SizeHalf: size_mask = OffW'(1);
      SizeWord: size_mask = OffW'(3);
      default:  size_mask = OffW'(7);
    endcase
    off_raw     = lsu.i_addr[OffW-1:0];
    off_eff     = off_raw & ~size_mask;
    c_addr_next = {lsu.i_addr[XLEN-1:OffW], OffW'(0)};
    // The aligner serves the store path while idle and the load path afterwards.
    al_size     = (state_q == StIdle) ? size_eff : op_size_q;
    al_off      = (state_q == StIdle) ? off_eff : op_off_q;
    timeout_hit = (TIMEOUT_CYC != 0) && ((cnt_q + CntW'(1)) == CntW'(TIMEOUT_CYC));
  end

`ifdef RAPID_MISALIGN_TRAP_EN
  logic misal;
  assign misal = dword_bad || (|(off_raw & size_mask));
`endif

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .size_i    (al_size),
    .off_i     (al_off),
    .unsigned_i(op_uns_q),
    .wdata_i   (lsu.i_wdata),
    .rdata_i   (cdata_q),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      c_req_q     <= 1'b0;
      c_we_q      <= 1'b0;
      c_addr_q    <= '0;
      c_wdata_q   <= '0;
      c_be_q      <= '0;
      res_q       <= '0;
      cdata_q     <= '0;
      rd_out_q    <= '0;
      op_rd_q     <= '0;
      fault_out_q <= FaultNone;
      op_fault_q  <= FaultNone;
      op_store_q  <= 1'b0;
      op_uns_q    <= 1'b0;
      op_size_q   <= SizeByte;
      op_off_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (lsu.i_valid) begin
            if (!(lsu.i_load || lsu.i_store)) begin
              valid_q     <= 1'b1;
              res_q       <= '0;
              rd_out_q    <= lsu.i_rd;
              fault_out_q <= FaultNone;
            end else begin
              op_store_q <= lsu.i_store;
              op_size_q  <= size_eff;
              op_off_q   <= off_eff;
              op_uns_q   <= lsu.i_unsigned;
              op_rd_q    <= lsu.i_rd;
              cnt_q      <= '0;
              ready_q    <= 1'b0;
`ifdef RAPID_MISALIGN_TRAP_EN
              if (misal) begin
                op_fault_q <= FaultMisalign;
                state_q    <= StResp;
              end else
`endif
              begin
                op_fault_q <= FaultNone;
                c_req_q    <= 1'b1;
                c_we_q     <= lsu.i_store;
                c_addr_q   <= c_addr_next;
                c_wdata_q  <= al_wdata;
                c_be_q     <= al_be;
                state_q    <= StReq;
              end
            end
          end
        end
        StReq: begin
          if (lsu.i_c_ack) begin
            cdata_q <= lsu.i_c_rdata;
            c_req_q <= 1'b0;
            c_we_q  <= 1'b0;
            c_be_q  <= '0;
            state_q <= StResp;
          end else if (timeout_hit) begin
            op_fault_q <= FaultTimeout;
            c_req_q    <= 1'b0;
            c_we_q     <= 1'b0;
            c_be_q     <= '0;
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          valid_q     <= 1'b1;
          res_q       <= (op_store_q || (op_fault_q != FaultNone)) ? '0 : al_rdata;
          rd_out_q    <= op_rd_q;
          fault_out_q <= op_fault_q;
          ready_q     <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lsu.o_ready   = ready_q;
  assign lsu.o_c_req   = c_req_q;
  assign lsu.o_c_we    = c_we_q;
  assign lsu.o_c_addr  = c_addr_q;
  assign lsu.o_c_wdata = c_wdata_q;
  assign lsu.o_c_be    = c_be_q;
  assign lsu.o_valid   = valid_q;
  assign lsu.o_rdata   = res_q;
  assign lsu.o_rd      = rd_out_q;
  assign lsu.o_fault   = fault_out_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: a 32-bit instance (default timeout) and a 64-bit
// instance with a 4-cycle timeout, each with a cache responder and result monitor.
module tb_lsu_stage;
  import rapid_pkg::*;

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic [1:0]  fault;
    int          cyc;
  } res_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wm;
    int          len;
    int          ack_dly;
    logic [63:0] ack_data;
  } req_t;

  typedef struct {
    logic        load, store, uns;
    logic [1:0]  size;
    logic [63:0] addr, wdata;
    logic [4:0]  rd;
    bit          has_req;
    req_t        rq;
    logic [63:0] res;
    logic [1:0]  fault;
    int          lat;
  } op_t;

  logic clk = 1'b0;
  logic rst32 = 1'b1;
  logic rst64 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  res_t res_q32[$], res_q64[$];
  req_t req_q32[$], req_q64[$];
  res_t e32, e64;
  req_t cur32, cur64;
  bit   in_req32 = 0, in_req64 = 0, late64 = 0;
  int   len32 = 0, len64 = 0;

  lsu_stage_if #(.XLEN(32)) bus32 ();
  lsu_stage_if #(.XLEN(64)) bus64 ();

  lsu_stage #(.XLEN(32), .TIMEOUT_CYC(255)) u_dut32 (.i_clk(clk), .i_reset(rst32), .lsu(bus32));
  lsu_stage #(.XLEN(64), .TIMEOUT_CYC(4))   u_dut64 (.i_clk(clk), .i_reset(rst64), .lsu(bus64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Result monitors
  always @(negedge clk) begin
    if (bus32.o_valid === 1'b1) begin
      if (res_q32.size() == 0) chk("valid32_unexpected", 64'd1, 64'd0);
      else begin
        e32 = res_q32.pop_front();
        chk("rdata32", {32'b0, bus32.o_rdata}, e32.rdata);
        chk("rd32", 64'(bus32.o_rd), 64'(e32.rd));
        chk("fault32", 64'(bus32.o_fault), 64'(e32.fault));
        chk("latency32", 64'(cyc), 64'(e32.cyc));
      end
    end
    if (bus64.o_valid === 1'b1) begin
      if (res_q64.size() == 0) chk("valid64_unexpected", 64'd1, 64'd0);
      else begin
        e64 = res_q64.pop_front();
        chk("rdata64", bus64.o_rdata, e64.rdata);
        chk("rd64", 64'(bus64.o_rd), 64'(e64.rd));
        chk("fault64", 64'(bus64.o_fault), 64'(e64.fault));
        chk("latency64", 64'(cyc), 64'(e64.cyc));
      end
    end
  end

  // Cache responders: check request fields, stability and length; ack after ack_dly cycles.
  always @(negedge clk) begin
    bus32.i_c_ack = 1'b0;
    if (bus32.o_c_req === 1'b1) begin
      if (!in_req32) begin
        if (req_q32.size() == 0) chk("req32_unexpected", 64'd1, 64'd0);
        else begin
          cur32 = req_q32.pop_front();
          in_req32 = 1;
          len32 = 0;
          chk("c_we32", 64'(bus32.o_c_we), 64'(cur32.we));
          chk("c_addr32", 64'(bus32.o_c_addr), cur32.addr);
          chk("c_be32", 64'(bus32.o_c_be), 64'(cur32.be[3:0]));
          if (cur32.we) chk("c_wdata32", 64'(bus32.o_c_wdata & {{8{bus32.o_c_be[3]}},
            {8{bus32.o_c_be[2]}}, {8{bus32.o_c_be[1]}}, {8{bus32.o_c_be[0]}}}), cur32.wm);
        end
      end else chk("c_addr_stable32", 64'(bus32.o_c_addr), cur32.addr);
      if (in_req32) begin
        len32++;
        chk("ready_low32", 64'(bus32.o_ready), 64'd0);
        if (len32 - 1 == cur32.ack_dly) begin
          bus32.i_c_ack = 1'b1;
          bus32.i_c_rdata = cur32.ack_data[31:0];
        end
      end
    end else if (in_req32) begin
      chk("req_len32", 64'(len32), 64'(cur32.len));
      in_req32 = 0;
    end
  end

  always @(negedge clk) begin
    bus64.i_c_ack = 1'b0;
    if (bus64.o_c_req === 1'b1) begin
      if (!in_req64) begin
        if (req_q64.size() == 0) chk("req64_unexpected", 64'd1, 64'd0);
        else begin
          cur64 = req_q64.pop_front();
          in_req64 = 1;
          len64 = 0;
          chk("c_we64", 64'(bus64.o_c_we), 64'(cur64.we));
          chk("c_addr64", bus64.o_c_addr, cur64.addr);
          chk("c_be64", 64'(bus64.o_c_be), 64'(cur64.be));
        end
      end else chk("c_addr_stable64", bus64.o_c_addr, cur64.addr);
      if (in_req64) begin
        len64++;
        chk("ready_low64", 64'(bus64.o_ready), 64'd0);
        if (len64 - 1 == cur64.ack_dly) begin
          bus64.i_c_ack = 1'b1;
          bus64.i_c_rdata = cur64.ack_data;
        end
      end
    end else begin
      if (in_req64) begin
        chk("req_len64", 64'(len64), 64'(cur64.len));
        in_req64 = 0;
      end
      if (late64) begin
        bus64.i_c_ack = 1'b1;
        bus64.i_c_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        late64 = 0;
      end
    end
  end

  task automatic issue(input bit w64, input op_t op);
    int n = 0;
    int acc;
    res_t r;
    @(negedge clk);
    while (((w64 ? bus64.o_ready : bus32.o_ready) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(n < 50), 64'd1);
    if (n >= 50) return;
    if (w64) begin
      bus64.i_valid = 1'b1; bus64.i_load = op.load; bus64.i_store = op.store;
      bus64.i_size = op.size; bus64.i_unsigned = op.uns; bus64.i_addr = op.addr;
      bus64.i_wdata = op.wdata; bus64.i_rd = op.rd;
    end else begin
      bus32.i_valid = 1'b1; bus32.i_load = op.load; bus32.i_store = op.store;
      bus32.i_size = op.size; bus32.i_unsigned = op.uns; bus32.i_addr = op.addr[31:0];
      bus32.i_wdata = op.wdata[31:0]; bus32.i_rd = op.rd;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus32.i_valid = 1'b0;
    bus64.i_valid = 1'b0;
    if (op.has_req) begin
      if (w64) req_q64.push_back(op.rq);
      else req_q32.push_back(op.rq);
    end
    if (op.lat > 0) begin
      r.rdata = op.res; r.rd = op.rd; r.fault = op.fault; r.cyc = acc + op.lat - 1;
      if (w64) res_q64.push_back(r);
      else res_q32.push_back(r);
    end
  endtask

  function automatic op_t mk(logic ld, logic st, logic [1:0] sz, logic un, logic [63:0] a,
                             logic [63:0] wd, logic [4:0] rd, logic [63:0] res,
                             logic [1:0] flt, int lat);
    op_t o;
    o.load = ld; o.store = st; o.size = sz; o.uns = un; o.addr = a; o.wdata = wd;
    o.rd = rd; o.res = res; o.fault = flt; o.lat = lat; o.has_req = 1'b0;
    o.rq.we = 1'b0; o.rq.addr = '0; o.rq.be = '0; o.rq.wm = '0; o.rq.len = 0;
    o.rq.ack_dly = 0; o.rq.ack_data = '0;
    return o;
  endfunction

  function automatic op_t wr(op_t o, logic we, logic [63:0] a, logic [7:0] be,
                             logic [63:0] wm, int len, int dly, logic [63:0] data);
    op_t r = o;
    r.has_req = 1'b1;
    r.rq.we = we; r.rq.addr = a; r.rq.be = be; r.rq.wm = wm; r.rq.len = len;
    r.rq.ack_dly = dly; r.rq.ack_data = data;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus32.i_valid = 0; bus32.i_load = 0; bus32.i_store = 0; bus32.i_size = 0;
    bus32.i_unsigned = 0; bus32.i_addr = 0; bus32.i_wdata = 0; bus32.i_rd = 0;
    bus32.i_c_ack = 0; bus32.i_c_rdata = 0;
    bus64.i_valid = 0; bus64.i_load = 0; bus64.i_store = 0; bus64.i_size = 0;
    bus64.i_unsigned = 0; bus64.i_addr = 0; bus64.i_wdata = 0; bus64.i_rd = 0;
    bus64.i_c_ack = 0; bus64.i_c_rdata = 0;
    repeat (3) @(negedge clk);
    rst32 = 0;
    rst64 = 0;
    @(negedge clk);
    chk("rst_ready32", 64'(bus32.o_ready), 64'd1);
    chk("rst_valid32", 64'(bus32.o_valid), 64'd0);
    chk("rst_req32", 64'(bus32.o_c_req), 64'd0);
    chk("rst_be32", 64'(bus32.o_c_be), 64'd0);
    chk("rst_rdata32", 64'(bus32.o_rdata), 64'd0);
    chk("rst_fault32", 64'(bus32.o_fault), 64'd0);
    chk("rst_ready64", 64'(bus64.o_ready), 64'd1);
    chk("rst_req64", 64'(bus64.o_c_req), 64'd0);

    // 32-bit: lb sign-extend, sh, delayed lw, misaligned lw, pass-through, lh/lhu, sb, ld+st
    issue(0, wr(mk(1, 0, 0, 0, 'h1003, 0, 5, 'hFFFF_FF80, 0, 3),
                0, 'h1000, 8'b1000, 0, 1, 0, 'h80FF_FF12));
    issue(0, wr(mk(0, 1, 1, 0, 'h2002, 'hABCD, 7, 0, 0, 3),
                1, 'h2000, 8'b1100, 'hABCD_0000, 1, 0, 0));
    issue(0, wr(mk(1, 0, 2, 0, 'h3000, 0, 9, 'hDEAD_BEEF, 0, 8),
                0, 'h3000, 8'b1111, 0, 6, 5, 'hDEAD_BEEF));
`ifdef RAPID_MISALIGN_TRAP_EN
    issue(0, mk(1, 0, 2, 0, 'h1001, 0, 10, 0, 1, 2));
`else
    issue(0, wr(mk(1, 0, 2, 0, 'h1001, 0, 10, 'h1234_5678, 0, 3),
                0, 'h1000, 8'b1111, 0, 1, 0, 'h1234_5678));
`endif
    issue(0, mk(0, 0, 2, 0, 'h7000, 'h55, 3, 0, 0, 1));
    issue(0, wr(mk(1, 0, 1, 1, 'h4002, 0, 12, 'h0000_9ABC, 0, 3),
                0, 'h4000, 8'b1100, 0, 1, 0, 'h9ABC_0000));
    issue(0, wr(mk(1, 0, 1, 0, 'h4002, 0, 13, 'hFFFF_9ABC, 0, 3),
                0, 'h4000, 8'b1100, 0, 1, 0, 'h9ABC_0000));
    issue(0, wr(mk(0, 1, 0, 0, 'h5001, 'h1234_5677, 14, 0, 0, 3),
                1, 'h5000, 8'b0010, 'h0000_7700, 1, 0, 0));
    issue(0, wr(mk(1, 1, 2, 0, 'h6000, 'hCAFE_F00D, 15, 0, 0, 3),
                1, 'h6000, 8'b1111, 'hCAFE_F00D, 1, 0, 'h1111_1111));

    // 64-bit: lw in upper lanes, ld timeout with late ack, reset in REQ, ld after reset
    issue(1, wr(mk(1, 0, 2, 0, 'h14, 0, 1, 'hFFFF_FFFF_8000_0001, 0, 3),
                0, 'h10, 8'hF0, 0, 1, 0, 'h8000_0001_0000_0000));
    issue(1, wr(mk(1, 0, 3, 0, 'h10, 0, 11, 0, 2, 6), 0, 'h10, 8'hFF, 0, 4, 1000, 0));
    late64 = 1;
    issue(1, wr(mk(1, 0, 3, 0, 'h8, 0, 4, 0, 0, 0), 0, 'h8, 8'hFF, 0, 1, 1000, 0));
    rst64 = 1;
    @(posedge clk);
    #1;
    rst64 = 0;
    chk("midrst_req64", 64'(bus64.o_c_req), 64'd0);
    chk("midrst_ready64", 64'(bus64.o_ready), 64'd1);
    chk("midrst_valid64", 64'(bus64.o_valid), 64'd0);
    issue(1, wr(mk(1, 0, 3, 0, 'h8, 0, 2, 'h0123_4567_89AB_CDEF, 0, 4),
                0, 'h8, 8'hFF, 0, 2, 1, 'h0123_4567_89AB_CDEF));

    repeat (15) @(negedge clk);
    chk("res_q32_drained", 64'(res_q32.size()), 64'd0);
    chk("res_q64_drained", 64'(res_q64.size()), 64'd0);
    chk("req_q32_drained", 64'(req_q32.size()), 64'd0);
    chk("req_q64_drained", 64'(req_q64.size()), 64'd0);
    chk("req_idle", 64'({in_req32, in_req64}), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
